// File: rtl/makina_isa_pkg.sv
// ISA constants and the decoded-bundle type shared by the decode stage and its core.
package makina_isa_pkg;

  // Instruction class codes, taken from instr[15:14]
  localparam logic [1:0] CLS_MEM = 2'b00;
  localparam logic [1:0] CLS_ALU = 2'b01;
  localparam logic [1:0] CLS_JMP = 2'b10;
  localparam logic [1:0] CLS_EXT = 2'b11;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_IMM = 5'b01010;
  localparam logic [2:0] JMP_NOP = 3'b111;

  // Widest prefix payload; the raw immediate is {prefix, 7-bit field} at most.
  // The stage resizes this raw value to XLEN, so the struct is XLEN-independent.
  localparam int PFX_W_MAX = 13;
  localparam int IMM_RAW_W = PFX_W_MAX + 7;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_PFX_HELD = 1'b1
  } pfx_state_e;

  typedef struct packed {
    logic [1:0]           instr_class;
    logic [4:0]           alu_ctrl;
    logic [2:0]           reg_dst;
    logic [2:0]           reg_rs1;
    logic [2:0]           reg_rs2;
    logic [IMM_RAW_W-1:0] imm_raw;
    logic                 reg_write;
    logic                 alu_src_imm;
    logic                 mem_write;
    logic                 wb_sel;
    logic [2:0]           jump_ctrl;
    logic                 illegal;
  } decode_bundle_t;

  // All-controls-off bundle: zeros everywhere except "no jump"
  function automatic decode_bundle_t bundle_default();
    decode_bundle_t b;
    b           = '0;
    b.jump_ctrl = JMP_NOP;
    return b;
  endfunction

endpackage

// File: rtl/decode_core.sv
// Combinational field decoder. Applies a held prefix to memory and ALU_IMM
// immediates and reports prefix instructions and illegal encodings/sequences.
module decode_core
  import makina_isa_pkg::*;
#(
  parameter int PFX_W = 13
) (
  input  logic [15:0]      i_instr,
  input  logic             i_pfx_valid,
  input  logic [PFX_W-1:0] i_pfx_reg,
  output decode_bundle_t   o_bundle,
  output logic             o_is_pfx,
  output logic             o_illegal
);

  logic [PFX_W_MAX-1:0] w_pfx_ext;
  logic                 w_uses_pfx;
  logic                 w_bad_enc;

  assign w_pfx_ext = PFX_W_MAX'(i_pfx_reg);

  // Decode fields by class; a held prefix only merges into memory / ALU_IMM immediates
  always_comb begin
    o_bundle             = bundle_default();
    o_bundle.instr_class = i_instr[15:14];
    o_is_pfx             = 1'b0;
    w_uses_pfx           = 1'b0;
    w_bad_enc            = 1'b0;
    case (i_instr[15:14])
      CLS_MEM: begin
        w_uses_pfx           = 1'b1;
        o_bundle.reg_dst     = i_instr[12:10];
        o_bundle.reg_rs1     = i_instr[9:7];
        o_bundle.alu_ctrl    = ALU_ADD;
        o_bundle.alu_src_imm = 1'b1;
        o_bundle.imm_raw     = i_pfx_valid ? {w_pfx_ext, i_instr[6:0]}
                                           : {{PFX_W_MAX{1'b0}}, i_instr[6:0]};
        if (i_instr[13]) begin
          o_bundle.mem_write = 1'b1;
          o_bundle.reg_rs2   = i_instr[12:10];
        end else begin
          o_bundle.reg_write = 1'b1;
          o_bundle.wb_sel    = 1'b1;
        end
      end
      CLS_ALU: begin
        o_bundle.alu_ctrl  = i_instr[13:9];
        o_bundle.reg_dst   = i_instr[8:6];
        o_bundle.reg_rs1   = i_instr[5:3];
        o_bundle.reg_rs2   = i_instr[2:0];
        o_bundle.reg_write = 1'b1;
        if (i_instr[13:9] == ALU_IMM) begin
          w_uses_pfx           = 1'b1;
          o_bundle.alu_src_imm = 1'b1;
          o_bundle.imm_raw     = i_pfx_valid ? {1'b0, w_pfx_ext, i_instr[5:0]}
                                             : {{(PFX_W_MAX+1){1'b0}}, i_instr[5:0]};
        end
      end
      CLS_JMP: begin
        if (i_instr[13:11] != JMP_NOP) begin
          o_bundle.jump_ctrl = i_instr[13:11];
          o_bundle.reg_rs1   = i_instr[10:8];
          o_bundle.reg_rs2   = i_instr[7:5];
        end
      end
      default: begin
        if (i_instr[13]) w_bad_enc = 1'b1;
        else             o_is_pfx  = 1'b1;
      end
    endcase
    // A prefix followed by anything that cannot absorb it is a bad sequence
    o_illegal = w_bad_enc || (i_pfx_valid && !w_uses_pfx && !o_is_pfx);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a valid/ready output register, a prefix
// register that widens the next immediate, illegal flagging and flush.
//
// Handshake: an input transfer happens on a rising edge where in_valid and
// in_ready are both high; an output transfer where out_valid and out_ready are
// both high. in_ready = !out_valid || out_ready and never looks at in_valid.
// A valid bundle is held unchanged until it transfers.
module decode_stage
  import makina_isa_pkg::*;
#(
  parameter int XLEN  = 16,  // at least 16
  parameter int PFX_W = 13   // 1..13
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      alu_ctrl,
  output logic [2:0]      reg_dst,
  output logic [2:0]      reg_rs1,
  output logic [2:0]      reg_rs2,
  output logic [XLEN-1:0] imm_se,
  output logic            reg_write,
  output logic            alu_src_imm,
  output logic            mem_write,
  output logic            reg_write_back_sel,
  output logic [2:0]      jump_ctrl,
  output logic [1:0]      instr_class,
  output logic            illegal,
  output logic            o_dbg_state
);

  pfx_state_e       r_state;
  pfx_state_e       w_state_nxt;
  logic [PFX_W-1:0] r_pfx_reg;
  logic             r_out_valid;
  decode_bundle_t   r_bundle;
  decode_bundle_t   w_bundle;
  decode_bundle_t   w_emit;
  logic             w_pfx_valid;
  logic             w_is_pfx;
  logic             w_illegal;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_emit_fire;

  assign in_ready    = !r_out_valid || out_ready;
  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = r_out_valid && out_ready;
  assign w_emit_fire = w_in_fire && !w_is_pfx && !flush;
  assign w_pfx_valid = (r_state == ST_PFX_HELD);

  decode_core #(
    .PFX_W(PFX_W)
  ) u_core (
    .i_instr    (instr),
    .i_pfx_valid(w_pfx_valid),
    .i_pfx_reg  (r_pfx_reg),
    .o_bundle   (w_bundle),
    .o_is_pfx   (w_is_pfx),
    .o_illegal  (w_illegal)
  );

  // Merge the sequence/encoding verdict into the bundle that gets registered
  always_comb begin
    w_emit         = w_bundle;
    w_emit.illegal = w_illegal;
  end

  // Prefix FSM next state: flush wins, otherwise each accepted instruction decides
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else if (w_in_fire) begin
      w_state_nxt = w_is_pfx ? ST_PFX_HELD : ST_IDLE;
    end
  end

  // Prefix FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Prefix payload: loaded by PFX, cleared once any other instruction consumes or discards it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pfx_reg <= '0;
    end else if (flush) begin
      r_pfx_reg <= '0;
    end else if (w_in_fire) begin
      r_pfx_reg <= w_is_pfx ? instr[PFX_W-1:0] : '0;
    end
  end

  // Output valid: set by an emitting accept, cleared by drain or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_emit_fire) begin
      r_out_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  // Bundle register: only written by an emitting accept, so it holds under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_bundle <= bundle_default();
    else if (w_emit_fire) r_bundle <= w_emit;
  end

  assign out_valid          = r_out_valid;
  assign alu_ctrl           = r_bundle.alu_ctrl;
  assign reg_dst            = r_bundle.reg_dst;
  assign reg_rs1            = r_bundle.reg_rs1;
  assign reg_rs2            = r_bundle.reg_rs2;
  assign imm_se             = XLEN'(r_bundle.imm_raw);
  assign reg_write          = r_bundle.reg_write;
  assign alu_src_imm        = r_bundle.alu_src_imm;
  assign mem_write          = r_bundle.mem_write;
  assign reg_write_back_sel = r_bundle.wb_sel;
  assign jump_ctrl          = r_bundle.jump_ctrl;
  assign instr_class        = r_bundle.instr_class;
  assign illegal            = r_bundle.illegal;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: a table of single instructions with hand-computed
// bundles, then hand-written prefix, backpressure, flush and reset sequences.
module tb_decode_stage;

  localparam int XLEN  = 16;
  localparam int PFX_W = 13;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [15:0]     instr = '0;
  logic            in_ready;
  logic            out_valid;
  logic [4:0]      alu_ctrl;
  logic [2:0]      reg_dst, reg_rs1, reg_rs2;
  logic [XLEN-1:0] imm_se;
  logic            reg_write, alu_src_imm, mem_write, reg_write_back_sel;
  logic [2:0]      jump_ctrl;
  logic [1:0]      instr_class;
  logic            illegal;
  logic            dbg_state;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .PFX_W(PFX_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .instr             (instr),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .alu_ctrl          (alu_ctrl),
    .reg_dst           (reg_dst),
    .reg_rs1           (reg_rs1),
    .reg_rs2           (reg_rs2),
    .imm_se            (imm_se),
    .reg_write         (reg_write),
    .alu_src_imm       (alu_src_imm),
    .mem_write         (mem_write),
    .reg_write_back_sel(reg_write_back_sel),
    .jump_ctrl         (jump_ctrl),
    .instr_class       (instr_class),
    .illegal           (illegal),
    .o_dbg_state       (dbg_state)
  );

  // ---------------- expected-value types ----------------
  typedef struct packed {
    logic [4:0]  alu;
    logic [2:0]  dst;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    logic        rw;
    logic        asi;
    logic        mw;
    logic        wb;
    logic [2:0]  jc;
    logic [1:0]  cls;
    logic        il;
  } exp_t;

  typedef struct packed {
    logic [15:0] ins;
    exp_t        exp;
  } vec_t;

  localparam int EW = $bits(exp_t);

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  vec_t vecs[9];

  function automatic exp_t mk(input logic [4:0] alu, input logic [2:0] dst,
                              input logic [2:0] rs1, input logic [2:0] rs2,
                              input logic [15:0] imm, input logic rw, input logic asi,
                              input logic mw, input logic wb, input logic [2:0] jc,
                              input logic [1:0] cls, input logic il);
    return {alu, dst, rs1, rs2, imm, rw, asi, mw, wb, jc, cls, il};
  endfunction

  function automatic exp_t cur();
    return {alu_ctrl, reg_dst, reg_rs1, reg_rs2, imm_se, reg_write, alu_src_imm,
            mem_write, reg_write_back_sel, jump_ctrl, instr_class, illegal};
  endfunction

  // ---------------- checkers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input exp_t exp);
    exp_t act;
    act = cur();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every output transfer must match the oldest expected bundle
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_bundle got=%h want=none", cur());
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if (cur() !== exp_t'(e)) begin
          n_bad++;
          $display("FAIL bundle got=%h want=%h", cur(), e);
        end
      end
    end
  end

  // ---------------- driver tasks (called #1 after a rising edge) ----------------
  task automatic push(input logic [15:0] ins);
    int n;
    n = 0;
    in_valid = 1'b1;
    instr    = ins;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout got=in_ready_low want=accept instr=%h", ins);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  exp_t d_ill;
  exp_t e;

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{16'h0485, mk(5'd0,  3'd1, 3'd1, 3'd0, 16'h0005, 1, 1, 0, 1, 3'd7, 2'd0, 0)};
    vecs[1] = '{16'h2C82, mk(5'd0,  3'd3, 3'd1, 3'd3, 16'h0002, 0, 1, 1, 0, 3'd7, 2'd0, 0)};
    vecs[2] = '{16'h429C, mk(5'd1,  3'd2, 3'd3, 3'd4, 16'h0000, 1, 0, 0, 0, 3'd7, 2'd1, 0)};
    vecs[3] = '{16'h5577, mk(5'd10, 3'd5, 3'd6, 3'd7, 16'h0037, 1, 1, 0, 0, 3'd7, 2'd1, 0)};
    vecs[4] = '{16'h8120, mk(5'd0,  3'd0, 3'd1, 3'd1, 16'h0000, 0, 0, 0, 0, 3'd0, 2'd2, 0)};
    vecs[5] = '{16'hB8FF, mk(5'd0,  3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 0, 0, 3'd7, 2'd2, 0)};
    vecs[6] = '{16'h9C45, mk(5'd0,  3'd0, 3'd4, 3'd2, 16'h0000, 0, 0, 0, 0, 3'd3, 2'd2, 0)};
    vecs[7] = '{16'hE000, mk(5'd0,  3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 0, 0, 3'd7, 2'd3, 1)};
    vecs[8] = '{16'hFFFF, mk(5'd0,  3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 0, 0, 3'd7, 2'd3, 1)};
    d_ill   = vecs[7].exp;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_state", dbg_state, 0);
    chk_b("rst_bundle", mk(0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 3'd7, 2'd0, 0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Table: back-to-back single instructions, drained every cycle
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(vecs[i].exp);
      push(vecs[i].ins);
    end
    idle(2);
    chk("table_drained", exp_q.size(), 0);

    // Prefixed ST: the PFX cycle yields no bundle, then one widened ST
    push(16'hC003);
    chk("pfx_no_bundle", out_valid, 0);
    chk("pfx_state_held", dbg_state, 1);
    exp_q.push_back(mk(0, 3'd3, 3'd1, 3'd3, 16'h0182, 0, 1, 1, 0, 3'd7, 2'd0, 0));
    push(16'h2C82);
    chk("pfx_st_state_idle", dbg_state, 0);
    idle(2);
    chk("pfx_st_single", out_valid, 0);

    // PFX overwrite then ALU_IMM: last prefix wins, no illegal
    push(16'hC001);
    push(16'hC00A);
    exp_q.push_back(mk(5'd10, 3'd5, 3'd6, 3'd7, 16'h02B7, 1, 1, 0, 0, 3'd7, 2'd1, 0));
    push(16'h5577);

    // Full-width prefix truncated to XLEN on LD
    push(16'hDFFF);
    exp_q.push_back(mk(0, 3'd1, 3'd1, 3'd0, 16'hFF85, 1, 1, 0, 1, 3'd7, 2'd0, 0));
    push(16'h0485);

    // Prefix misuse: jump flagged, following ALU_IMM un-prefixed
    push(16'hC003);
    exp_q.push_back(mk(0, 3'd0, 3'd1, 3'd1, 16'h0, 0, 0, 0, 0, 3'd0, 2'd2, 1));
    push(16'h8120);
    exp_q.push_back(vecs[3].exp);
    push(16'h5577);

    // Prefix before register ALU and before a bad encoding
    push(16'hC003);
    exp_q.push_back(mk(5'd1, 3'd2, 3'd3, 3'd4, 16'h0, 1, 0, 0, 0, 3'd7, 2'd1, 1));
    push(16'h429C);
    push(16'hC003);
    exp_q.push_back(d_ill);
    push(16'hE000);
    idle(2);
    chk("pfx_seq_drained", exp_q.size(), 0);

    // Backpressure: held bundle stable, next instruction waits, no loss/duplicate
    out_ready = 1'b0;
    push(16'h0485);
    in_valid = 1'b1;
    instr    = 16'h429C;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk_b("bp_hold", vecs[0].exp);
      @(posedge clk); #1;
    end
    exp_q.push_back(vecs[0].exp);
    exp_q.push_back(vecs[2].exp);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    idle(2);
    chk("bp_no_dup", out_valid, 0);
    chk("bp_drained", exp_q.size(), 0);

    // Flush in PFX_HELD: prefix discarded
    push(16'hC003);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_state", dbg_state, 0);
    exp_q.push_back(vecs[0].exp);
    push(16'h0485);
    idle(1);

    // Flush drops an instruction accepted in the same cycle
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = 16'h429C;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_drop", out_valid, 0);
    idle(1);

    // Asynchronous reset clears a held bundle without a clock edge
    out_ready = 1'b0;
    push(16'h0485);
    chk("ar_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk_b("ar_bundle", mk(0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 3'd7, 2'd0, 0));
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle(1);

    // Reset while a prefix is held discards it
    push(16'hC003);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_pfx_state", dbg_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    exp_q.push_back(vecs[0].exp);
    push(16'h0485);
    idle(3);
    chk("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
